lpc_io_target: RTL
==================

// Module: lpc_io_target
// PURPOSE
//  LPC bus-side I/O target transactor. Decodes host I/O read/write cycles on LAD/LFRAME_N
//  and drives Addr/Wr/Rd/DataWrSW into the LPC register file. Returns register read data
//  (DataRd, muxed from DataReg by the parent) on LAD. Sits between the LPC pins and the
//  register file inside Lpc.
// PARAMETERS
//  BASE_ADDR    16'h0800  I/O window base; cycle claimed when addr[15:8]==BASE_ADDR[15:8]
//  WAIT_CYCLES  2         long-wait SYNC count (used only with LPC_LONG_WAIT_EN), 1..15
// PORTS
//  LpcClock   in   1  33 MHz LPC clock
//  PciReset   in   1  asynchronous, active-low reset
//  LFRAME_N   in   1  LPC frame, active low
//  LAD_in     in   4  LAD pin input
//  LAD_out    out  4  LAD drive value
//  LAD_oe     out  1  LAD output enable (1 = target drives)
//  DataRd     in   8  read data for Addr (DataReg[Addr]), sampled by this block
//  Addr       out  8  register offset, addr[7:0] of last claimed cycle
//  Wr         out  1  one-cycle write strobe
//  Rd         out  1  one-cycle read strobe (drives read-clear in register file)
//  DataWrSW   out  8  write data of last claimed write cycle
// BEHAVIOUR
//  Reset: Addr=0, DataWrSW=0, Wr=0, Rd=0, LAD_oe=0, LAD_out=4'hF, state=IDLE.
//  States: IDLE, CYC, ADR3, ADR2, ADR1, ADR0, WD0, WD1, HTAR0, HTAR1, [LWAIT], SYNC,
//   RD0, RD1, PTAR0, PTAR1. All outputs registered, aligned to the state's clock cycle.
//  START: any cycle with LFRAME_N=0 and LAD_in=4'h0 -> CYC (also aborts any cycle in
//   progress, incl. while target drives; LAD_oe drops next cycle). LFRAME_N=0 with other
//   LAD value -> IDLE.
//  CYC: LAD_in[3:2]!=2'b00 (not I/O) -> IDLE. LAD_in[1]: 0=read, 1=write; latched.
//  ADR3..ADR0: address nibbles MSB first. ADR3/ADR2 compared to BASE_ADDR[15:12]/[11:8];
//   any mismatch -> IDLE (no drive, no strobes, Addr unchanged). ADR1/ADR0 into a shadow;
//   Addr updated from shadow at end of ADR0 only if claimed.
//  Write: ADR0 -> WD0 (data[3:0]) -> WD1 (data[7:4]; DataWrSW loaded at end of WD1)
//   -> HTAR0 -> HTAR1 -> SYNC -> PTAR0 -> PTAR1 -> IDLE.
//  Read:  ADR0 -> HTAR0 -> HTAR1 (DataRd captured at end of HTAR1) -> SYNC -> RD0
//   (LAD_out=data[3:0]) -> RD1 (data[7:4]) -> PTAR0 -> PTAR1 -> IDLE.
//  Drive: SYNC LAD_out=4'h0; PTAR0 LAD_out=4'hF; LAD_oe=1 in SYNC,LWAIT,RD0,RD1,PTAR0
//   only; 0 elsewhere. LAD_out=4'hF whenever LAD_oe=0.
//  Strobes: Wr=1 for exactly the SYNC cycle of a claimed write; Rd=1 for exactly the SYNC
//   cycle of a claimed read (after capture, so read-clear never corrupts returned data).
//   Never both; never asserted for unclaimed or aborted cycles.
//  Latency from START cycle (n): write SYNC/Wr at n+10, PTAR n+11..12; read SYNC/Rd at
//   n+8, data n+9..10, PTAR n+11..12 (without long wait).
//  Abort during SYNC: strobe already issued stays issued (single pulse); no data driven.
//  Reset mid-cycle: immediate return to reset values, LAD released asynchronously.
//  Back-to-back: new START accepted in PTAR1 or any later cycle.
// CONFIGURATION
//  LPC_LONG_WAIT_EN defined: HTAR1 -> LWAIT for WAIT_CYCLES cycles driving LAD_out=4'h6
//   (LAD_oe=1), then SYNC; all SYNC-relative timing shifts by WAIT_CYCLES; Wr/Rd still in
//   SYNC. Not defined: LWAIT state and WAIT_CYCLES logic absent; HTAR1 -> SYNC directly.
// TESTING
//  Write 0x0809=0x5A (LAD: 0,1..wait 2? cyc=4'h2,0,8,0,9,A,5,F,F) -> Wr@n+10, Addr=0x09,
//   DataWrSW=0x5A, LAD 0 at n+10, F at n+11, oe=0 at n+12.
//  Read 0x0800, DataRd=0x12 -> Rd@n+8, LAD 0,2,1,F at n+8..n+11; DataRd changed to 0x00
//   at n+9 does not alter returned nibbles.
//  Read 0x0900 (mismatch) -> LAD_oe stays 0, Rd/Wr stay 0, Addr unchanged.
//  START then LFRAME_N=0/LAD=0 again during ADR1 -> restart at CYC; no strobe from first.
//  PciReset low during read RD0 -> LAD_oe=0, LAD_out=F, Addr=0 immediately; next read ok.
//  LPC_LONG_WAIT_EN, WAIT_CYCLES=2, read 0x0800 -> LAD 6,6 at n+8..9, SYNC 0 + Rd at n+10.

Source files
------------

// File: rtl/lpc_io_target.sv
// lpc_io_target: LPC bus-side I/O target transactor.
// Decodes host I/O read/write cycles on LAD/LFRAME_N inside a 256-byte window
// (BASE_ADDR[15:8]) and hands Addr/Wr/Rd/DataWrSW to the register file.
// Read data (DataRd) is captured before the Rd strobe so a read-clear in the
// register file cannot corrupt the returned nibbles.
// Optional feature: define LPC_LONG_WAIT_EN to insert WAIT_CYCLES long-wait
// SYNC nibbles (4'h6) between HTAR1 and SYNC.
module lpc_io_target #(
  parameter logic [15:0] BASE_ADDR   = 16'h0800,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LFRAME_N,
  input  logic [3:0] LAD_in,
  output logic [3:0] LAD_out,
  output logic       LAD_oe,
  input  logic [7:0] DataRd,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic       Rd,
  output logic [7:0] DataWrSW
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] CYC   = 4'd1;
  localparam logic [3:0] ADR3  = 4'd2;
  localparam logic [3:0] ADR2  = 4'd3;
  localparam logic [3:0] ADR1  = 4'd4;
  localparam logic [3:0] ADR0  = 4'd5;
  localparam logic [3:0] WD0   = 4'd6;
  localparam logic [3:0] WD1   = 4'd7;
  localparam logic [3:0] HTAR0 = 4'd8;
  localparam logic [3:0] HTAR1 = 4'd9;
  localparam logic [3:0] SYNC  = 4'd10;
  localparam logic [3:0] RD0   = 4'd11;
  localparam logic [3:0] RD1   = 4'd12;
  localparam logic [3:0] PTAR0 = 4'd13;
  localparam logic [3:0] PTAR1 = 4'd14;
`ifdef LPC_LONG_WAIT_EN
  localparam logic [3:0] LWAIT = 4'd15;
`endif

  logic [3:0] state;
  logic [3:0] nextState;
  logic       isWrite;
  logic [3:0] adrHi;
  logic [3:0] wdLo;
  logic [7:0] rdData;
`ifdef LPC_LONG_WAIT_EN
  logic [3:0] waitCnt;
`endif

  // Next-state decode; LFRAME_N low overrides every state (START or abort).
  always_comb begin
    nextState = state;
    if (!LFRAME_N) begin
      nextState = (LAD_in == 4'h0) ? CYC : IDLE;
    end else begin
      case (state)
        IDLE:  nextState = IDLE;
        CYC:   nextState = (LAD_in[3:2] == 2'b00) ? ADR3 : IDLE;
        ADR3:  nextState = (LAD_in == BASE_ADDR[15:12]) ? ADR2 : IDLE;
        ADR2:  nextState = (LAD_in == BASE_ADDR[11:8]) ? ADR1 : IDLE;
        ADR1:  nextState = ADR0;
        ADR0:  nextState = isWrite ? WD0 : HTAR0;
        WD0:   nextState = WD1;
        WD1:   nextState = HTAR0;
        HTAR0: nextState = HTAR1;
`ifdef LPC_LONG_WAIT_EN
        HTAR1: nextState = LWAIT;
        LWAIT: nextState = (waitCnt == '0) ? SYNC : LWAIT;
`else
        HTAR1: nextState = SYNC;
`endif
        SYNC:  nextState = isWrite ? PTAR0 : RD0;
        RD0:   nextState = RD1;
        RD1:   nextState = PTAR0;
        PTAR0: nextState = PTAR1;
        PTAR1: nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) state <= IDLE;
    else           state <= nextState;
  end

  // Cycle decode datapath: direction, address shadow, write data, read capture.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      isWrite  <= 1'b0;
      adrHi    <= '0;
      wdLo     <= '0;
      rdData   <= '0;
      Addr     <= '0;
      DataWrSW <= '0;
    end else begin
      if (state == CYC) isWrite <= LAD_in[1];
      if (state == ADR1 && nextState == ADR0) adrHi <= LAD_in;
      if (state == ADR0 && (nextState == WD0 || nextState == HTAR0))
        Addr <= {adrHi, LAD_in};
      if (state == WD0 && nextState == WD1) wdLo <= LAD_in;
      if (state == WD1 && nextState == HTAR0) DataWrSW <= {LAD_in, wdLo};
      if (state == HTAR1) rdData <= DataRd;
    end
  end

`ifdef LPC_LONG_WAIT_EN
  // Long-wait counter: loaded on leaving HTAR1, counts down through LWAIT.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset)            waitCnt <= '0;
    else if (state == HTAR1)  waitCnt <= 4'(WAIT_CYCLES - 1);
    else if (state == LWAIT)  waitCnt <= waitCnt - 4'd1;
  end
`endif

  // Registered pin drive and strobes, decoded from the state being entered.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      LAD_oe  <= 1'b0;
      LAD_out <= 4'hF;
      Wr      <= 1'b0;
      Rd      <= 1'b0;
    end else begin
      Wr <= (nextState == SYNC) && isWrite;
      Rd <= (nextState == SYNC) && !isWrite;
      case (nextState)
        SYNC:  begin LAD_oe <= 1'b1; LAD_out <= 4'h0;        end
`ifdef LPC_LONG_WAIT_EN
        LWAIT: begin LAD_oe <= 1'b1; LAD_out <= 4'h6;        end
`endif
        RD0:   begin LAD_oe <= 1'b1; LAD_out <= rdData[3:0]; end
        RD1:   begin LAD_oe <= 1'b1; LAD_out <= rdData[7:4]; end
        PTAR0: begin LAD_oe <= 1'b1; LAD_out <= 4'hF;        end
        default: begin LAD_oe <= 1'b0; LAD_out <= 4'hF;      end
      endcase
    end
  end

endmodule
